// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: ramps rail enables up in index order gated by PG, down in reverse.
// Optional PG stability filter is built when PWR_SEQ_PG_FILTER_EN is defined.
module pwr_seq_ctrl #(
  parameter int NUM_RAILS  = 4,
  parameter int DLY_CYCLES = 100,
  parameter int PG_TIMEOUT = 1000,
  parameter int CNT_W      = 16
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iPwrOn,
  input  logic [NUM_RAILS-1:0] iPg,
  input  logic                 iClearFault,
  output logic [NUM_RAILS-1:0] oEn,
  output logic                 oAllPg,
  output logic                 oFault,
  output logic [2:0]           oFaultRail,
  output logic [2:0]           oState
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_UP     = 3'd1,
    S_UP_DLY = 3'd2,
    S_ON     = 3'd3,
    S_DN     = 3'd4,
    S_DN_DLY = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [2:0]       LAST_IDX  = 3'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(DLY_CYCLES - 1);
  // The one-cycle DN state counts toward the spacing between disables.
  localparam int               DN_LAST_I = (DLY_CYCLES >= 2) ? DLY_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] DN_LAST   = CNT_W'(DN_LAST_I);

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_RAILS-1:0]   en_q, en_d;
  logic                   all_pg_q;
  logic                   fault_q, fault_d;
  logic [2:0]             fault_rail_q, fault_rail_d;

  logic                   pwr_s1_q, pwr_s2_q, pwr_dly_q;
  logic [NUM_RAILS-1:0]   pg_s1_q, pg_s2_q, pg_dly_q;
  logic [NUM_RAILS-1:0]   pg_lvl;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pwr_s1_q  <= 1'b0;
      pwr_s2_q  <= 1'b0;
      pwr_dly_q <= 1'b0;
      pg_s1_q   <= '0;
      pg_s2_q   <= '0;
      pg_dly_q  <= '0;
    end else begin
      pwr_s1_q  <= iPwrOn;
      pwr_s2_q  <= pwr_s1_q;
      pwr_dly_q <= pwr_s2_q;
      pg_s1_q   <= iPg;
      pg_s2_q   <= pg_s1_q;
      pg_dly_q  <= pg_lvl;
    end
  end

`ifdef PWR_SEQ_PG_FILTER_EN
  for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_pg_filt
    logic       filt_q;
    logic [1:0] run_q;
    // Filtered level flips on the 4th consecutive sample that disagrees with it.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        filt_q <= 1'b0;
        run_q  <= 2'd0;
      end else if (pg_s2_q[gi] == filt_q) begin
        run_q <= 2'd0;
      end else if (run_q == 2'd3) begin
        filt_q <= pg_s2_q[gi];
        run_q  <= 2'd0;
      end else begin
        run_q <= run_q + 2'd1;
      end
    end
    assign pg_lvl[gi] = filt_q;
  end
`else
  assign pg_lvl = pg_s2_q;
`endif

  logic                 pwr_rise, pwr_fall;
  logic [NUM_RAILS-1:0] pg_fall;
  logic                 pg_cur;
  logic [2:0]           fall_idx;
  logic [2:0]           idx_inc;
  logic [CNT_W-1:0]     cnt_inc;

  assign pwr_rise = pwr_s2_q & ~pwr_dly_q;
  assign pwr_fall = ~pwr_s2_q & pwr_dly_q;
  assign pg_fall  = pg_dly_q & ~pg_lvl;
  assign pg_cur   = |(pg_lvl & (NUM_RAILS'(1) << idx_q));
  assign idx_inc  = idx_q + 3'd1;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    fall_idx = 3'd0;
    for (int k = NUM_RAILS - 1; k >= 0; k--) begin
      if (pg_fall[k]) fall_idx = 3'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    case (state_q)
      S_OFF: begin
        if (pwr_rise) begin
          idx_d   = 3'd0;
          en_d    = NUM_RAILS'(1);
          cnt_d   = '0;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (!pg_cur && cnt_q == TO_LAST) begin
          en_d         = '0;
          fault_d      = 1'b1;
          fault_rail_d = idx_q;
          state_d      = S_FAULT;
        end else if (!pwr_s2_q) begin
          state_d = S_DN;
        end else if (pg_cur) begin
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? S_ON : S_UP_DLY;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_UP_DLY: begin
        if (!pwr_s2_q) begin
          state_d = S_DN;
        end else if (cnt_q == UP_LAST) begin
          idx_d   = idx_inc;
          en_d    = en_q | (NUM_RAILS'(1) << idx_inc);
          cnt_d   = '0;
          state_d = S_UP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ON: begin
        if (|pg_fall) begin
          en_d         = '0;
          fault_d      = 1'b1;
          fault_rail_d = fall_idx;
          state_d      = S_FAULT;
        end else if (pwr_fall) begin
          state_d = S_DN;
        end
      end
      S_DN: begin
        en_d    = en_q & ~(NUM_RAILS'(1) << idx_q);
        cnt_d   = '0;
        state_d = S_DN_DLY;
      end
      S_DN_DLY: begin
        if (cnt_q >= DN_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd0) begin
            state_d = S_OFF;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = S_DN;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FAULT: begin
        en_d = '0;
        if (iClearFault && !pwr_s2_q) begin
          fault_d      = 1'b0;
          fault_rail_d = 3'd0;
          state_d      = S_OFF;
        end
      end
      default: begin
        en_d    = '0;
        state_d = S_OFF;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= S_OFF;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      en_q         <= '0;
      all_pg_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      all_pg_q     <= (state_d == S_ON);
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  assign oEn        = en_q;
  assign oAllPg     = all_pg_q;
  assign oFault     = fault_q;
  assign oFaultRail = fault_rail_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: ramp up, ramp down, PG timeout, PG loss, abort, reset.
module tb_pwr_seq_ctrl;

  localparam int NR = 4;
`ifdef PWR_SEQ_PG_FILTER_EN
  localparam int PG_LAT = 7;
`else
  localparam int PG_LAT = 3;
`endif

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iPwrOn;
  logic [NR-1:0] iPg;
  logic          iClearFault;
  logic [NR-1:0] oEn;
  logic          oAllPg;
  logic          oFault;
  logic [2:0]    oFaultRail;
  logic [2:0]    oState;

  int errors = 0;
  int checks = 0;

  pwr_seq_ctrl #(
    .NUM_RAILS  (NR),
    .DLY_CYCLES (8),
    .PG_TIMEOUT (20),
    .CNT_W      (16)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iPwrOn      (iPwrOn),
    .iPg         (iPg),
    .iClearFault (iClearFault),
    .oEn         (oEn),
    .oAllPg      (oAllPg),
    .oFault      (oFault),
    .oFaultRail  (oFaultRail),
    .oState      (oState)
  );

  always #5 iClk = ~iClk;

  task automatic tick(input int c);
    repeat (c) @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Cycles until oEn changes; -1 if it never does within the budget.
  task automatic wait_en(output int n);
    logic [NR-1:0] prev;
    prev = oEn;
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick(1);
      if (oEn !== prev) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick(1);
      if (oState === tgt) begin
        n = k;
        break;
      end
    end
  endtask

  // Raise iPwrOn and return each PG 5 cycles after its enable, for npg rails.
  task automatic power_up(input int npg);
    int n;
    iPwrOn = 1'b1;
    wait_en(n);
    for (int r = 0; r < npg; r++) begin
      tick(5);
      iPg[r] = 1'b1;
      if (r == NR - 1) wait_state(3'd3, n);
      else wait_en(n);
    end
  endtask

  task automatic clear_fault();
    iPwrOn = 1'b0;
    tick(3);
    iClearFault = 1'b1;
    tick(1);
    iClearFault = 1'b0;
  endtask

  initial begin
    int n;
    logic [NR-1:0] exp_en;
    iRst_n      = 1'b0;
    iPwrOn      = 1'b0;
    iPg         = '0;
    iClearFault = 1'b0;
    tick(2);
    chk("rst_en", oEn, 0);
    chk("rst_state", oState, 0);
    chk("rst_fault", oFault, 0);
    chk("rst_allpg", oAllPg, 0);
    chk("rst_rail", oFaultRail, 0);
    iRst_n = 1'b1;
    tick(3);

    // Power-up with PG 5 cycles after each enable.
    iPwrOn = 1'b1;
    wait_en(n);
    chk("up_en0_lat", n, 3);
    chk("up_en0", oEn, 4'b0001);
    chk("up_state", oState, 1);
    exp_en = 4'b0001;
    for (int r = 0; r < NR - 1; r++) begin
      tick(5);
      iPg[r] = 1'b1;
      wait_state(3'd2, n);
      chk("up_pg_lat", n, PG_LAT);
      chk("up_allpg_low", oAllPg, 0);
      wait_en(n);
      exp_en = {exp_en[NR-2:0], 1'b1};
      chk("up_en_dly", n, 8);
      chk("up_en_step", oEn, exp_en);
    end
    tick(5);
    iPg[NR-1] = 1'b1;
    wait_state(3'd3, n);
    chk("on_lat", n, PG_LAT);
    chk("on_allpg", oAllPg, 1);
    chk("on_en", oEn, 4'b1111);

    // Power-down from ON.
    tick(4);
    iPwrOn = 1'b0;
    wait_en(n);
    chk("dn_lat", n, 4);
    chk("dn_en3", oEn, 4'b0111);
    chk("dn_allpg", oAllPg, 0);
    wait_en(n);
    chk("dn_gap2", n, 8);
    chk("dn_en2", oEn, 4'b0011);
    wait_en(n);
    chk("dn_gap1", n, 8);
    chk("dn_en1", oEn, 4'b0001);
    wait_en(n);
    chk("dn_gap0", n, 8);
    chk("dn_en0", oEn, 4'b0000);
    wait_state(3'd0, n);
    chk("dn_off_lat", n, 7);
    chk("dn_fault", oFault, 0);
    iPg = '0;
    tick(8);

    // PG timeout on rail 2.
    power_up(2);
    chk("to_en", oEn, 4'b0111);
    wait_state(3'd6, n);
    chk("to_lat", n, 20);
    chk("to_en_clr", oEn, 4'b0000);
    chk("to_fault", oFault, 1);
    chk("to_rail", oFaultRail, 2);
    iClearFault = 1'b1;
    tick(1);
    iClearFault = 1'b0;
    tick(2);
    chk("to_clr_ign", oState, 6);
    chk("to_clr_ign_flt", oFault, 1);
    clear_fault();
    chk("to_clr_state", oState, 0);
    chk("to_clr_fault", oFault, 0);
    chk("to_clr_rail", oFaultRail, 0);
    iPg = '0;
    tick(8);

    // PG loss in ON.
    power_up(NR);
    chk("loss_on", oState, 3);
    iPg[1] = 1'b0;
    tick(1);
    iPg[1] = 1'b1;
`ifdef PWR_SEQ_PG_FILTER_EN
    tick(10);
    chk("glitch_ignored", oState, 3);
    iPg[1] = 1'b0;
    tick(5);
    iPg[1] = 1'b1;
`endif
    wait_state(3'd6, n);
    chk("loss_lat", n, 2);
    chk("loss_rail", oFaultRail, 1);
    chk("loss_en", oEn, 4'b0000);
    chk("loss_allpg", oAllPg, 0);
    clear_fault();
    chk("loss_clr", oState, 0);
    iPg = '0;
    tick(8);

    // Abort during UP_DLY after rail 1.
    power_up(1);
    chk("ab_en", oEn, 4'b0011);
    tick(5);
    iPg[1] = 1'b1;
    wait_state(3'd2, n);
    chk("ab_updly", n, PG_LAT);
    iPwrOn = 1'b0;
    wait_en(n);
    chk("ab_lat", n, 4);
    chk("ab_en1", oEn, 4'b0001);
    wait_en(n);
    chk("ab_gap", n, 8);
    chk("ab_en0", oEn, 4'b0000);
    wait_state(3'd0, n);
    chk("ab_off", n, 7);
    iPg = '0;
    tick(8);

    // Asynchronous reset mid-UP, then restart.
    power_up(0);
    chk("rs_up", oState, 1);
    tick(2);
    #2;
    iRst_n = 1'b0;
    iPwrOn = 1'b0;
    #1;
    chk("rs_en_async", oEn, 0);
    chk("rs_state", oState, 0);
    @(posedge iClk);
    #3;
    iRst_n = 1'b1;
    tick(1);
    tick(3);
    chk("rs_idle", oState, 0);
    iPwrOn = 1'b1;
    wait_en(n);
    chk("rs_restart_lat", n, 3);
    chk("rs_restart_en", oEn, 4'b0001);
    chk("rs_restart_st", oState, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
